// File: rtl/pmem_write_buffer_pkg.sv
// Shared types for the physical-memory write buffer: FSM states, entry layout
// and the line-tag width derived from the 16-byte line offset.
package pmem_write_buffer_pkg;

  localparam int WB_ADDR_W   = 16;
  localparam int WB_LINE_W   = 128;
  localparam int WB_OFFSET_W = 4;
  localparam int WB_TAG_W    = WB_ADDR_W - WB_OFFSET_W;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_MEM_READ,
    WB_DRAIN,
    WB_RESP
  } wb_state_t;

  typedef struct packed {
    logic                 valid;
    logic [WB_TAG_W-1:0]  tag;
    logic [WB_LINE_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/pmem_write_buffer_tag_cam.sv
// Combinational tag compare across all buffer entries; the head entry is
// masked out while it is being drained so it is never forwarded or coalesced.
module wb_tag_cam #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 12,
  parameter int IDX_W = 2
) (
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]            tag,
  input  logic                        exclude_en,
  input  logic [IDX_W-1:0]            exclude_index,
  output logic                        hit,
  output logic [IDX_W-1:0]            hit_index
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    hit       = 1'b0;
    hit_index = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && valid[i] && tags[i] == tag &&
          !(exclude_en && exclude_index == IDX_W'(i))) begin
        hit       = 1'b1;
        hit_index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pmem_write_buffer.sv
// Line write buffer between the victim cache and physical memory.
// Define WB_READ_FORWARD_EN to serve read hits from the buffer; otherwise a
// read hit drains the buffer until the matching line has reached memory.
module pmem_write_buffer
  import pmem_write_buffer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LINE_W   = WB_LINE_W,
  parameter int OFFSET_W = WB_OFFSET_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up_read,
  input  logic              up_write,
  input  logic [15:0]       up_address,
  input  logic [LINE_W-1:0] up_wdata,
  output logic [LINE_W-1:0] up_rdata,
  output logic              up_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [15:0]       mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = 16 - OFFSET_W;

  wb_state_t state, state_next;
  wb_entry_t entries [DEPTH];
  logic [IDX_W-1:0] head, tail, hit_index;
  logic [IDX_W:0]   count;
  logic             quiet, hit, full;
  logic             do_fwd, do_coalesce, do_push, start_read, start_drain, retire;
  logic [TAG_W-1:0] req_tag;
  logic [DEPTH-1:0]            valid_vec;
  logic [DEPTH-1:0][TAG_W-1:0] tag_vec;

  assign req_tag = up_address[15:OFFSET_W];
  assign full    = (count == (IDX_W+1)'(DEPTH));
  assign retire  = (state == WB_DRAIN) && mem_resp;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries[i].valid;
      tag_vec[i]   = entries[i].tag;
    end
  end

  wb_tag_cam #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_cam (
    .valid        (valid_vec),
    .tags         (tag_vec),
    .tag          (req_tag),
    .exclude_en   (state == WB_DRAIN),
    .exclude_index(head),
    .hit          (hit),
    .hit_index    (hit_index)
  );

  // Requests still visible in the cycle after RESP belong to the finished
  // transaction, so IDLE neither serves them nor starts a drain then.
  always_comb begin
    state_next  = state;
    do_fwd      = 1'b0;
    do_coalesce = 1'b0;
    do_push     = 1'b0;
    start_read  = 1'b0;
    start_drain = 1'b0;
    case (state)
      WB_IDLE: if (!quiet) begin
        if (up_read) begin
`ifdef WB_READ_FORWARD_EN
          if (hit) begin
            do_fwd     = 1'b1;
            state_next = WB_RESP;
          end else begin
            start_read = 1'b1;
            state_next = WB_MEM_READ;
          end
`else
          if (hit) begin
            start_drain = 1'b1;
            state_next  = WB_DRAIN;
          end else begin
            start_read = 1'b1;
            state_next = WB_MEM_READ;
          end
`endif
        end else if (up_write) begin
          if (hit) begin
            do_coalesce = 1'b1;
            state_next  = WB_RESP;
          end else if (!full) begin
            do_push    = 1'b1;
            state_next = WB_RESP;
          end else begin
            start_drain = 1'b1;
            state_next  = WB_DRAIN;
          end
        end else if (count != '0) begin
          start_drain = 1'b1;
          state_next  = WB_DRAIN;
        end
      end
      WB_MEM_READ: if (mem_resp) state_next = WB_RESP;
      WB_DRAIN:    if (mem_resp) state_next = WB_IDLE;
      WB_RESP:     state_next = WB_IDLE;
      default:     state_next = WB_IDLE;
    endcase
  end

  assign up_resp   = (state == WB_RESP);
  assign mem_read  = (state == WB_MEM_READ);
  assign mem_write = (state == WB_DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WB_IDLE;
      quiet       <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      up_rdata    <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      // NOTE: entries are flops, not RAM, so they are cleared outright; only
      // the valid bits matter functionally.
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      state <= state_next;
      quiet <= (state == WB_RESP);
      if (do_fwd) up_rdata <= entries[hit_index].data;
      if (state == WB_MEM_READ && mem_resp) up_rdata <= mem_rdata;
      if (do_coalesce) entries[hit_index].data <= up_wdata;
      if (do_push) begin
        entries[tail] <= '{valid: 1'b1, tag: req_tag, data: up_wdata};
        tail          <= tail + IDX_W'(1);
      end
      if (start_read) mem_address <= up_address;
      if (start_drain) begin
        mem_address <= {entries[head].tag, {OFFSET_W{1'b0}}};
        mem_wdata   <= entries[head].data;
      end
      if (retire) begin
        entries[head].valid <= 1'b0;
        head                <= head + IDX_W'(1);
      end
      if (do_push)     count <= count + (IDX_W+1)'(1);
      else if (retire) count <= count - (IDX_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Directed bench for pmem_write_buffer with a small memory model that logs
// every completed memory transaction in order.
module tb_pmem_write_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         up_read, up_write;
  logic [15:0]  up_address;
  logic [127:0] up_wdata, up_rdata;
  logic         up_resp;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_resp = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  bit           mem_stall = 1'b0;
  int           mem_cnt = 0;
  int           rd_cycles = 0;
  bit           ev_wr   [64];
  logic [15:0]  ev_addr [64];
  logic [127:0] ev_data [64];
  int           n_ev = 0;

  always #5 clk = ~clk;

  pmem_write_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .up_read    (up_read),
    .up_write   (up_write),
    .up_address (up_address),
    .up_wdata   (up_wdata),
    .up_rdata   (up_rdata),
    .up_resp    (up_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  // Memory answers two cycles into a request; read data encodes the address.
  always @(negedge clk) begin
    if (reset) begin
      mem_resp = 1'b0;
      mem_cnt  = 0;
    end else begin
      if (mem_read) rd_cycles++;
      if (mem_resp) mem_resp = 1'b0;
      else if ((mem_read || mem_write) && !mem_stall) begin
        mem_cnt++;
        if (mem_cnt >= 2) begin
          mem_cnt   = 0;
          mem_resp  = 1'b1;
          mem_rdata = {8{mem_address}};
          if (n_ev < 64) begin
            ev_wr[n_ev]   = mem_write;
            ev_addr[n_ev] = mem_address;
            ev_data[n_ev] = mem_wdata;
            n_ev++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      assert (!(mem_read && mem_write)) else $error("mem_read and mem_write both high");
      assert (!(up_read && up_write)) else $error("up_read and up_write both high");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic do_req(input bit wr, input logic [15:0] addr, input logic [127:0] wdata,
                        output logic [127:0] rdata, output int cycles);
    @(negedge clk);
    up_read    = !wr;
    up_write   = wr;
    up_address = addr;
    up_wdata   = wdata;
    cycles     = 0;
    while (cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (up_resp) break;
    end
    if (!up_resp) begin
      vectors++; miscompares++;
      $display("FAIL req_timeout: addr %h got no up_resp, required one within 300 cycles", addr);
    end
    rdata    = up_rdata;
    up_read  = 1'b0;
    up_write = 1'b0;
  endtask

  task automatic drain_all();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dut.count == 0 && !mem_write && !mem_read) break;
    end
    if (i == 300) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: count %0d, required 0 within 300 cycles", dut.count);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (up_resp !== 1'b0) begin miscompares++; $display("FAIL rst_up_resp: got %b required 0", up_resp); end
    vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL rst_mem_read: got %b required 0", mem_read); end
    vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL rst_mem_write: got %b required 0", mem_write); end
    vectors++; if (up_rdata !== '0) begin miscompares++; $display("FAIL rst_up_rdata: got %h required 0", up_rdata); end
    vectors++; if (mem_address !== 16'h0) begin miscompares++; $display("FAIL rst_mem_address: got %h required 0", mem_address); end
    vectors++; if (mem_wdata !== '0) begin miscompares++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
    vectors++; if (dut.count !== 0) begin miscompares++; $display("FAIL rst_count: got %0d required 0", dut.count); end
  endtask

  task automatic test_coalesce();
    logic [127:0] a = {4{32'hAAAA_0001}};
    logic [127:0] b = {4{32'hBBBB_0002}};
    logic [127:0] rd;
    int cy;
    int base = n_ev;
    do_req(1'b1, 16'h1000, a, rd, cy);
    do_req(1'b1, 16'h1008, b, rd, cy);
    vectors++; if (dut.count !== 1) begin miscompares++; $display("FAIL coal_count: got %0d required 1", dut.count); end
    drain_all();
    vectors++; if (n_ev !== base + 1) begin miscompares++; $display("FAIL coal_nev: got %0d required %0d", n_ev, base + 1); end
    vectors++; if (ev_wr[base] !== 1'b1 || ev_addr[base] !== 16'h1000) begin
      miscompares++; $display("FAIL coal_addr: got wr=%b %h required wr=1 1000", ev_wr[base], ev_addr[base]);
    end
    vectors++; if (ev_data[base] !== b) begin miscompares++; $display("FAIL coal_data: got %h required %h", ev_data[base], b); end
  endtask

  task automatic test_full();
    logic [127:0] rd;
    int cy;
    int base = n_ev;
    for (int i = 0; i < 5; i++)
      do_req(1'b1, 16'h4000 + 16'(i * 16), {4{32'hD000_0000 + i}}, rd, cy);
    vectors++; if (n_ev !== base + 1) begin miscompares++; $display("FAIL full_nev: got %0d required %0d", n_ev, base + 1); end
    vectors++; if (ev_wr[base] !== 1'b1 || ev_addr[base] !== 16'h4000) begin
      miscompares++; $display("FAIL full_first_drain: got wr=%b %h required wr=1 4000", ev_wr[base], ev_addr[base]);
    end
    vectors++; if (ev_data[base] !== {4{32'hD000_0000}}) begin
      miscompares++; $display("FAIL full_first_data: got %h required %h", ev_data[base], {4{32'hD000_0000}});
    end
    vectors++; if (dut.count !== 4) begin miscompares++; $display("FAIL full_count: got %0d required 4", dut.count); end
    drain_all();
    for (int k = 1; k < 5; k++) begin
      vectors++;
      if (ev_wr[base+k] !== 1'b1 || ev_addr[base+k] !== 16'h4000 + 16'(k * 16)) begin
        miscompares++;
        $display("FAIL full_order%0d: got wr=%b %h required wr=1 %h", k, ev_wr[base+k], ev_addr[base+k], 16'h4000 + 16'(k * 16));
      end
    end
  endtask

  task automatic test_read_priority();
    logic [127:0] rd;
    int cy;
    int base = n_ev;
    do_req(1'b1, 16'h5000, {4{32'hE000_0000}}, rd, cy);
    do_req(1'b1, 16'h5010, {4{32'hE000_0001}}, rd, cy);
    do_req(1'b0, 16'h2000, '0, rd, cy);
    vectors++; if (ev_wr[base] !== 1'b0 || ev_addr[base] !== 16'h2000) begin
      miscompares++; $display("FAIL prio_first: got wr=%b %h required wr=0 2000", ev_wr[base], ev_addr[base]);
    end
    vectors++; if (rd !== {8{16'h2000}}) begin miscompares++; $display("FAIL prio_rdata: got %h required %h", rd, {8{16'h2000}}); end
    vectors++; if (dut.count !== 2) begin miscompares++; $display("FAIL prio_count: got %0d required 2", dut.count); end
    drain_all();
    vectors++; if (ev_wr[base+1] !== 1'b1 || ev_addr[base+1] !== 16'h5000) begin
      miscompares++; $display("FAIL prio_drain0: got wr=%b %h required wr=1 5000", ev_wr[base+1], ev_addr[base+1]);
    end
    vectors++; if (ev_wr[base+2] !== 1'b1 || ev_addr[base+2] !== 16'h5010) begin
      miscompares++; $display("FAIL prio_drain1: got wr=%b %h required wr=1 5010", ev_wr[base+2], ev_addr[base+2]);
    end
  endtask

`ifdef WB_READ_FORWARD_EN
  task automatic test_forward();
    logic [127:0] a = {4{32'hF0F0_1234}};
    logic [127:0] rd;
    int cy;
    int base = n_ev;
    int rc0  = rd_cycles;
    do_req(1'b1, 16'h1000, a, rd, cy);
    do_req(1'b0, 16'h1000, '0, rd, cy);
    vectors++; if (rd !== a) begin miscompares++; $display("FAIL fwd_rdata: got %h required %h", rd, a); end
    // one ignored cycle after the write's RESP, then IDLE -> RESP
    vectors++; if (cy !== 2) begin miscompares++; $display("FAIL fwd_latency: got %0d cycles required 2", cy); end
    vectors++; if (rd_cycles !== rc0 || n_ev !== base) begin
      miscompares++; $display("FAIL fwd_no_mem: got %0d read cycles %0d events required 0 0", rd_cycles - rc0, n_ev - base);
    end
    vectors++; if (dut.count !== 1) begin miscompares++; $display("FAIL fwd_count: got %0d required 1", dut.count); end
    drain_all();
  endtask
`else
  task automatic test_no_forward();
    logic [127:0] rd;
    int cy;
    int base = n_ev;
    do_req(1'b1, 16'h3100, {4{32'h3100_0000}}, rd, cy);
    do_req(1'b1, 16'h3000, {4{32'h3000_0000}}, rd, cy);
    do_req(1'b0, 16'h3000, '0, rd, cy);
    vectors++; if (ev_wr[base] !== 1'b1 || ev_addr[base] !== 16'h3100) begin
      miscompares++; $display("FAIL nofwd_drain0: got wr=%b %h required wr=1 3100", ev_wr[base], ev_addr[base]);
    end
    vectors++; if (ev_wr[base+1] !== 1'b1 || ev_addr[base+1] !== 16'h3000) begin
      miscompares++; $display("FAIL nofwd_drain1: got wr=%b %h required wr=1 3000", ev_wr[base+1], ev_addr[base+1]);
    end
    vectors++; if (ev_wr[base+2] !== 1'b0 || ev_addr[base+2] !== 16'h3000) begin
      miscompares++; $display("FAIL nofwd_read: got wr=%b %h required wr=0 3000", ev_wr[base+2], ev_addr[base+2]);
    end
    vectors++; if (rd !== {8{16'h3000}}) begin miscompares++; $display("FAIL nofwd_rdata: got %h required %h", rd, {8{16'h3000}}); end
    vectors++; if (dut.count !== 0) begin miscompares++; $display("FAIL nofwd_count: got %0d required 0", dut.count); end
  endtask
`endif

  task automatic test_reset_mid_drain();
    logic [127:0] rd;
    int cy;
    int base;
    mem_stall = 1'b1;
    base = n_ev;
    do_req(1'b1, 16'h6000, {4{32'h6666_0000}}, rd, cy);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_write) break;
    end
    vectors++; if (mem_write !== 1'b1) begin miscompares++; $display("FAIL rmd_drain_start: got mem_write %b required 1", mem_write); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL rmd_mem_write: got %b required 0", mem_write); end
    vectors++; if (dut.count !== 0) begin miscompares++; $display("FAIL rmd_count: got %0d required 0", dut.count); end
    vectors++; if (mem_address !== 16'h0) begin miscompares++; $display("FAIL rmd_mem_address: got %h required 0", mem_address); end
    @(negedge clk);
    reset     = 1'b0;
    mem_stall = 1'b0;
    do_req(1'b0, 16'h6000, '0, rd, cy);
    vectors++; if (n_ev !== base + 1 || ev_wr[base] !== 1'b0 || ev_addr[base] !== 16'h6000) begin
      miscompares++; $display("FAIL rmd_fresh_read: got %0d events wr=%b %h required 1 wr=0 6000", n_ev - base, ev_wr[base], ev_addr[base]);
    end
    vectors++; if (rd !== {8{16'h6000}}) begin miscompares++; $display("FAIL rmd_rdata: got %h required %h", rd, {8{16'h6000}}); end
  endtask

  initial begin
    reset      = 1'b1;
    up_read    = 1'b0;
    up_write   = 1'b0;
    up_address = '0;
    up_wdata   = '0;
    test_reset();
    test_coalesce();
    test_full();
    test_read_priority();
`ifdef WB_READ_FORWARD_EN
    test_forward();
`else
    test_no_forward();
`endif
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
